// File: rtl/approx_mult_error_analyzer.sv
// Exhaustive operand sweep for a WIDTH x WIDTH approximate multiplier under test,
// accumulating error statistics against the exact product with latency alignment.
module approx_mult_error_analyzer #(
    parameter int WIDTH   = 8,
    parameter int MUT_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop_on_err,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [2*WIDTH-1:0]   mut_y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     total_cnt,
    output logic [2*WIDTH:0]     correct_cnt,
    output logic [4*WIDTH:0]     sum_abs_err,
    output logic [2*WIDTH-1:0]   max_abs_err,
    output logic [WIDTH-1:0]     err_a,
    output logic [WIDTH-1:0]     err_b,
    output logic [2*WIDTH-1:0]   err_y,
    output logic                 err_seen
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = 2 * WIDTH + 1;
    localparam int SW = 4 * WIDTH + 1;
    localparam int DW = (MUT_LAT > 1) ? $clog2(MUT_LAT) : 1;
    localparam logic [WIDTH-1:0] OP_MAX     = {WIDTH{1'b1}};
    localparam logic [DW-1:0]    DRAIN_LAST = DW'((MUT_LAT > 0) ? (MUT_LAT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic            stop_r;
    logic [DW-1:0]   drain_cnt_r;

    logic            start_go_s;
    logic            issue_s;
    logic            last_pair_s;
    logic            cmp_valid_s;
    logic [WIDTH-1:0] cmp_a_s;
    logic [WIDTH-1:0] cmp_b_s;
    logic [PW-1:0]   cmp_exact_s;
    logic [PW-1:0]   abs_err_s;
    logic            neq_s;
    logic            mismatch_s;
    logic            stop_now_s;

    function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x, input logic [PW-1:0] y);
        logic [PW-1:0] d;
        if (x >= y) begin
            d = x - y;
        end else begin
            d = y - x;
        end
        return d;
    endfunction

    // Sweep-control decodes and compare-side error terms
    always_comb begin
        start_go_s  = start && ((state_r == IDLE) || (state_r == DONE));
        issue_s     = (state_r == SWEEP);
        last_pair_s = (op_a == OP_MAX) && (op_b == OP_MAX);
        neq_s       = (mut_y != cmp_exact_s);
        mismatch_s  = cmp_valid_s && neq_s;
        stop_now_s  = mismatch_s && stop_r;
        abs_err_s   = abs_diff(mut_y, cmp_exact_s);
    end

    generate
        if (MUT_LAT == 0) begin : g_comb
            // Combinational MUT: the pair on op_a/op_b is compared in the same cycle
            always_comb begin
                cmp_valid_s = issue_s;
                cmp_a_s     = op_a;
                cmp_b_s     = op_b;
                cmp_exact_s = PW'(op_a) * PW'(op_b);
            end
        end else begin : g_pipe
            logic [MUT_LAT-1:0] pv_r;
            logic [WIDTH-1:0]   pa_r [MUT_LAT];
            logic [WIDTH-1:0]   pb_r [MUT_LAT];
            logic [PW-1:0]      px_r [MUT_LAT];

            // Reference delay line matching MUT latency; an early stop drops in-flight pairs
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv_r <= '0;
                    for (int i = 0; i < MUT_LAT; i++) begin
                        pa_r[i] <= '0;
                        pb_r[i] <= '0;
                        px_r[i] <= '0;
                    end
                end else begin
                    for (int i = MUT_LAT - 1; i > 0; i--) begin
                        pv_r[i] <= pv_r[i-1] && !stop_now_s;
                        pa_r[i] <= pa_r[i-1];
                        pb_r[i] <= pb_r[i-1];
                        px_r[i] <= px_r[i-1];
                    end
                    pv_r[0] <= issue_s && !stop_now_s;
                    pa_r[0] <= op_a;
                    pb_r[0] <= op_b;
                    px_r[0] <= PW'(op_a) * PW'(op_b);
                end
            end

            // Oldest delay-line stage lines up with the current mut_y
            always_comb begin
                cmp_valid_s = pv_r[MUT_LAT-1];
                cmp_a_s     = pa_r[MUT_LAT-1];
                cmp_b_s     = pb_r[MUT_LAT-1];
                cmp_exact_s = px_r[MUT_LAT-1];
            end
        end
    endgenerate

    // Sweep FSM: operand issue order, drain timing, latched stop mode and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            stop_r      <= 1'b0;
            drain_cnt_r <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_go_s) begin
                        state_r     <= SWEEP;
                        op_a        <= '0;
                        op_b        <= '0;
                        stop_r      <= stop_on_err;
                        drain_cnt_r <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (stop_now_s) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (last_pair_s) begin
                        // Operands stay on the final pair so they read back after the sweep
                        if (MUT_LAT > 0) begin
                            state_r     <= DRAIN;
                            drain_cnt_r <= '0;
                        end else begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        op_b <= op_b + WIDTH'(1'b1);
                        if (op_b == OP_MAX) begin
                            op_a <= op_a + WIDTH'(1'b1);
                        end
                    end
                end
                DRAIN: begin
                    if (stop_now_s || (drain_cnt_r == DRAIN_LAST)) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DW'(1'b1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Error statistics and first-mismatch capture, cleared when a sweep starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cnt   <= '0;
            correct_cnt <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            err_a       <= '0;
            err_b       <= '0;
            err_y       <= '0;
            err_seen    <= 1'b0;
        end else if (start_go_s) begin
            total_cnt   <= '0;
            correct_cnt <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            err_a       <= '0;
            err_b       <= '0;
            err_y       <= '0;
            err_seen    <= 1'b0;
        end else if (cmp_valid_s) begin
            total_cnt   <= total_cnt + CW'(1'b1);
            sum_abs_err <= sum_abs_err + SW'(abs_err_s);
            if (!neq_s) begin
                correct_cnt <= correct_cnt + CW'(1'b1);
            end
            if (abs_err_s > max_abs_err) begin
                max_abs_err <= abs_err_s;
            end
            if (neq_s && !err_seen) begin
                err_a    <= cmp_a_s;
                err_b    <= cmp_b_s;
                err_y    <= mut_y;
                err_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_error_analyzer.sv
// Bench for approx_mult_error_analyzer: three instances (4-bit comb, 4-bit 2-stage, 8-bit truncated MUT)
// checked every cycle against an index-driven sweep model plus hand-computed literals.
`timescale 1ns/1ps
module tb_approx_mult_error_analyzer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic start_bus, stop_bus, fault_en;
    int   active;
    int   n_checks, n_errors;

    function automatic logic [7:0] mut4(input logic [3:0] a, input logic [3:0] b, input logic f);
        if (f && a == 4'd3 && b == 4'd5) return 8'd14;
        return 8'(a) * 8'(b);
    endfunction

    // Truncated array multiplier: partial-product columns below 6 are dropped
    function automatic logic [15:0] mut8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'd0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (i + j >= 6 && a[i] && b[j]) acc = acc + (16'd1 << (i + j));
        return acc;
    endfunction

    logic s0, s2, s8;
    assign s0 = start_bus && (active == 0);
    assign s2 = start_bus && (active == 1);
    assign s8 = start_bus && (active == 2);

    logic [3:0] a0, b0, ea0, eb0; logic [7:0] y0, max0, ey0; logic [8:0] tot0, cor0; logic [16:0] sum0; logic busy0, done0, es0;
    logic [3:0] a2, b2, ea2, eb2; logic [7:0] y2, max2, ey2; logic [8:0] tot2, cor2; logic [16:0] sum2; logic busy2, done2, es2;
    logic [7:0] a8, b8, ea8, eb8; logic [15:0] y8, max8, ey8; logic [16:0] tot8, cor8; logic [32:0] sum8; logic busy8, done8, es8;

    assign y0 = mut4(a0, b0, fault_en);
    assign y8 = mut8(a8, b8);

    logic [7:0] r1 = 8'd0, r2 = 8'd0;
    always @(posedge clk) begin
        r1 <= mut4(a2, b2, fault_en);
        r2 <= r1;
    end
    assign y2 = r2;

    approx_mult_error_analyzer #(.WIDTH(4), .MUT_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(s0), .stop_on_err(stop_bus), .op_a(a0), .op_b(b0), .mut_y(y0),
        .busy(busy0), .done(done0), .total_cnt(tot0), .correct_cnt(cor0), .sum_abs_err(sum0),
        .max_abs_err(max0), .err_a(ea0), .err_b(eb0), .err_y(ey0), .err_seen(es0));

    approx_mult_error_analyzer #(.WIDTH(4), .MUT_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(s2), .stop_on_err(stop_bus), .op_a(a2), .op_b(b2), .mut_y(y2),
        .busy(busy2), .done(done2), .total_cnt(tot2), .correct_cnt(cor2), .sum_abs_err(sum2),
        .max_abs_err(max2), .err_a(ea2), .err_b(eb2), .err_y(ey2), .err_seen(es2));

    approx_mult_error_analyzer #(.WIDTH(8), .MUT_LAT(0)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .stop_on_err(stop_bus), .op_a(a8), .op_b(b8), .mut_y(y8),
        .busy(busy8), .done(done8), .total_cnt(tot8), .correct_cnt(cor8), .sum_abs_err(sum8),
        .max_abs_err(max8), .err_a(ea8), .err_b(eb8), .err_y(ey8), .err_seen(es8));

    logic [63:0] d_opa, d_opb, d_tot, d_cor, d_sum, d_max, d_ea, d_eb, d_ey;
    logic        d_busy, d_done, d_es;
    always_comb begin
        d_opa = 64'(a0); d_opb = 64'(b0); d_tot = 64'(tot0); d_cor = 64'(cor0); d_sum = 64'(sum0);
        d_max = 64'(max0); d_ea = 64'(ea0); d_eb = 64'(eb0); d_ey = 64'(ey0);
        d_busy = busy0; d_done = done0; d_es = es0;
        case (active)
            1: begin
                d_opa = 64'(a2); d_opb = 64'(b2); d_tot = 64'(tot2); d_cor = 64'(cor2); d_sum = 64'(sum2);
                d_max = 64'(max2); d_ea = 64'(ea2); d_eb = 64'(eb2); d_ey = 64'(ey2);
                d_busy = busy2; d_done = done2; d_es = es2;
            end
            2: begin
                d_opa = 64'(a8); d_opb = 64'(b8); d_tot = 64'(tot8); d_cor = 64'(cor8); d_sum = 64'(sum8);
                d_max = 64'(max8); d_ea = 64'(ea8); d_eb = 64'(eb8); d_ey = 64'(ey8);
                d_busy = busy8; d_done = done8; d_es = es8;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sweep model: pair k is issued k cycles after start and compared MUT latency later
    bit          model_on, m_stop, m_stopped, e_es;
    int          m_k, m_n, m_lat, m_w;
    logic [63:0] e_tot, e_cor, e_sum, e_max, e_ea, e_eb, e_ey;

    function automatic logic [63:0] model_y(input logic [63:0] a, input logic [63:0] b);
        if (active == 2) return 64'(mut8(a[7:0], b[7:0]));
        return 64'(mut4(a[3:0], b[3:0], fault_en));
    endfunction

    task automatic model_init(input int dut, input bit stop);
        m_w = (dut == 2) ? 8 : 4;
        m_n = 1 << (2 * m_w);
        m_lat = (dut == 1) ? 2 : 0;
        m_stop = stop; m_stopped = 1'b0; m_k = 0;
        e_tot = 64'd0; e_cor = 64'd0; e_sum = 64'd0; e_max = 64'd0;
        e_ea = 64'd0; e_eb = 64'd0; e_ey = 64'd0; e_es = 1'b0;
        model_on = 1'b1;
    endtask

    initial begin : compare_proc
        int idx, io;
        logic [63:0] pa, pb, ex, y, ad, mask;
        bit fin;
        forever begin
            @(negedge clk);
            if (model_on) begin
                mask = (64'd1 << m_w) - 64'd1;
                if (!m_stopped && m_k >= m_lat + 1 && m_k <= m_n + m_lat) begin
                    idx = m_k - m_lat - 1;
                    pa = 64'(idx) >> m_w; pb = 64'(idx) & mask;
                    ex = pa * pb; y = model_y(pa, pb);
                    ad = (y > ex) ? y - ex : ex - y;
                    e_tot = e_tot + 64'd1;
                    e_sum = e_sum + ad;
                    if (ad > e_max) e_max = ad;
                    if (y == ex) e_cor = e_cor + 64'd1;
                    else begin
                        if (!e_es) begin e_es = 1'b1; e_ea = pa; e_eb = pb; e_ey = y; end
                        if (m_stop) m_stopped = 1'b1;
                    end
                end
                fin = m_stopped || (m_k >= m_n + m_lat);
                chk("cyc_busy", 64'(d_busy), 64'(!fin));
                chk("cyc_done", 64'(d_done), 64'(fin));
                if (!m_stopped) begin
                    io = (m_k < m_n) ? m_k : m_n - 1;
                    chk("cyc_op_a", d_opa, 64'(io) >> m_w);
                    chk("cyc_op_b", d_opb, 64'(io) & mask);
                end
                chk("cyc_total", d_tot, e_tot);
                chk("cyc_correct", d_cor, e_cor);
                chk("cyc_sum", d_sum, e_sum);
                chk("cyc_max", d_max, e_max);
                chk("cyc_err_seen", 64'(d_es), 64'(e_es));
                chk("cyc_err_a", d_ea, e_ea);
                chk("cyc_err_b", d_eb, e_eb);
                chk("cyc_err_y", d_ey, e_ey);
                m_k++;
            end
        end
    end

    task automatic run_sweep(input int dut, input bit stop, input bit fault,
                             input int exp_edges, input int exp_busy, input int mid_at);
        int edges, busy_cycles, budget;
        bit seen;
        @(negedge clk);
        active = dut; fault_en = fault; stop_bus = stop; start_bus = 1'b1;
        @(posedge clk); #1;
        start_bus = 1'b0;
        model_init(dut, stop);
        edges = 0; seen = 1'b0;
        busy_cycles = d_busy ? 1 : 0;
        budget = m_n + m_lat + 16;
        while (!seen && edges < budget) begin
            @(posedge clk); #1;
            start_bus = 1'b0;
            edges++;
            if (edges == mid_at) start_bus = 1'b1;
            if (d_busy) busy_cycles++;
            seen = d_done;
        end
        start_bus = 1'b0;
        chk("done_timeout", 64'(seen), 64'd1);
        chk("done_edge", 64'(edges), 64'(exp_edges));
        chk("busy_cycles", 64'(busy_cycles), 64'(exp_busy));
        repeat (3) @(posedge clk);
        #1 model_on = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(d_busy), 64'd0);
        chk({tag, "_done"}, 64'(d_done), 64'd0);
        chk({tag, "_op_a"}, d_opa, 64'd0);
        chk({tag, "_op_b"}, d_opb, 64'd0);
        chk({tag, "_total"}, d_tot, 64'd0);
        chk({tag, "_correct"}, d_cor, 64'd0);
        chk({tag, "_sum"}, d_sum, 64'd0);
        chk({tag, "_max"}, d_max, 64'd0);
        chk({tag, "_err_seen"}, 64'(d_es), 64'd0);
        chk({tag, "_err_y"}, d_ey, 64'd0);
    endtask

    initial begin : main_proc
        logic [63:0] g_cor, g_sum, g_max, ex8, y8g, ad8;
        rst_n = 1'b0; start_bus = 1'b0; stop_bus = 1'b0; fault_en = 1'b0; active = 0;
        model_on = 1'b0; n_checks = 0; n_errors = 0;

        chk("pin_mut4_fault", 64'(mut4(4'd3, 4'd5, 1'b1)), 64'd14);
        chk("pin_mut4_exact", 64'(mut4(4'd3, 4'd5, 1'b0)), 64'd15);
        chk("pin_mut8_1_1", 64'(mut8(8'd1, 8'd1)), 64'd0);
        chk("pin_mut8_8_8", 64'(mut8(8'd8, 8'd8)), 64'd64);
        chk("pin_mut8_ff_ff", 64'(mut8(8'd255, 8'd255)), 64'd64704);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            active = d; #1;
            check_zero("reset");
        end
        @(negedge clk) rst_n = 1'b1;

        g_cor = 64'd0; g_sum = 64'd0; g_max = 64'd0;
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++) begin
                ex8 = 64'(a * b);
                y8g = 64'(mut8(8'(a), 8'(b)));
                ad8 = (y8g > ex8) ? y8g - ex8 : ex8 - y8g;
                if (ad8 == 64'd0) g_cor = g_cor + 64'd1;
                g_sum = g_sum + ad8;
                if (ad8 > g_max) g_max = ad8;
            end

        run_sweep(0, 1'b0, 1'b0, 256, 256, -1);
        chk("exact_total", d_tot, 64'd256);
        chk("exact_correct", d_cor, 64'd256);
        chk("exact_sum", d_sum, 64'd0);
        chk("exact_max", d_max, 64'd0);
        chk("exact_err_seen", 64'(d_es), 64'd0);

        run_sweep(0, 1'b0, 1'b1, 256, 256, -1);
        chk("fault_total", d_tot, 64'd256);
        chk("fault_correct", d_cor, 64'd255);
        chk("fault_sum", d_sum, 64'd1);
        chk("fault_max", d_max, 64'd1);
        chk("fault_err_a", d_ea, 64'd3);
        chk("fault_err_b", d_eb, 64'd5);
        chk("fault_err_y", d_ey, 64'd14);
        chk("fault_err_seen", 64'(d_es), 64'd1);

        run_sweep(1, 1'b0, 1'b1, 258, 258, -1);
        chk("lat2_total", d_tot, 64'd256);
        chk("lat2_correct", d_cor, 64'd255);
        chk("lat2_sum", d_sum, 64'd1);
        chk("lat2_max", d_max, 64'd1);
        chk("lat2_err_a", d_ea, 64'd3);
        chk("lat2_err_b", d_eb, 64'd5);
        chk("lat2_err_y", d_ey, 64'd14);

        run_sweep(0, 1'b1, 1'b1, 54, 54, -1);
        chk("stop_total", d_tot, 64'd54);
        chk("stop_correct", d_cor, 64'd53);
        chk("stop_err_a", d_ea, 64'd3);
        chk("stop_err_b", d_eb, 64'd5);
        chk("stop_err_seen", 64'(d_es), 64'd1);

        run_sweep(0, 1'b0, 1'b0, 256, 256, 40);
        chk("midstart_total", d_tot, 64'd256);
        chk("midstart_correct", d_cor, 64'd256);
        chk("midstart_err_seen", 64'(d_es), 64'd0);

        @(negedge clk);
        active = 0; fault_en = 1'b1; stop_bus = 1'b0; start_bus = 1'b1;
        @(posedge clk); #1;
        start_bus = 1'b0;
        model_init(0, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(d_busy), 64'd1);
        model_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("post_reset_idle");

        run_sweep(2, 1'b0, 1'b0, 65536, 65536, -1);
        chk("w8_total", d_tot, 64'd65536);
        chk("w8_correct", d_cor, g_cor);
        chk("w8_sum", d_sum, g_sum);
        chk("w8_max", d_max, g_max);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
